// File: rtl/sound_frame_sequencer_pkg.sv
// +--------------------------------------------------------------------------+
// | sound_pkg : shared constants and types for the sound frame sequencer      |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package sound_pkg;

  localparam logic [2:0] SEQ_STEP_0 = 3'd0;
  localparam logic [2:0] SEQ_STEP_1 = 3'd1;
  localparam logic [2:0] SEQ_STEP_2 = 3'd2;
  localparam logic [2:0] SEQ_STEP_3 = 3'd3;
  localparam logic [2:0] SEQ_STEP_4 = 3'd4;
  localparam logic [2:0] SEQ_STEP_5 = 3'd5;
  localparam logic [2:0] SEQ_STEP_6 = 3'd6;
  localparam logic [2:0] SEQ_STEP_7 = 3'd7;

  localparam int LEN_MAX_TONE = 64;
  localparam int LEN_MAX_WAVE = 256;

  localparam int CH1 = 0;
  localparam int CH2 = 1;
  localparam int CH3 = 2;
  localparam int CH4 = 3;

  localparam logic [15:0] NR10 = 16'hFF10;
  localparam logic [15:0] NR11 = 16'hFF11;
  localparam logic [15:0] NR12 = 16'hFF12;
  localparam logic [15:0] NR13 = 16'hFF13;
  localparam logic [15:0] NR14 = 16'hFF14;
  localparam logic [15:0] NR21 = 16'hFF16;
  localparam logic [15:0] NR22 = 16'hFF17;
  localparam logic [15:0] NR23 = 16'hFF18;
  localparam logic [15:0] NR24 = 16'hFF19;
  localparam logic [15:0] NR30 = 16'hFF1A;
  localparam logic [15:0] NR31 = 16'hFF1B;
  localparam logic [15:0] NR32 = 16'hFF1C;
  localparam logic [15:0] NR33 = 16'hFF1D;
  localparam logic [15:0] NR34 = 16'hFF1E;
  localparam logic [15:0] NR41 = 16'hFF20;
  localparam logic [15:0] NR42 = 16'hFF21;
  localparam logic [15:0] NR43 = 16'hFF22;
  localparam logic [15:0] NR44 = 16'hFF23;
  localparam logic [15:0] NR50 = 16'hFF24;
  localparam logic [15:0] NR51 = 16'hFF25;
  localparam logic [15:0] NR52 = 16'hFF26;

  typedef struct packed {
    logic length;
    logic sweep;
    logic envelope;
  } strobe_t;

  // Strobes issued when the given step executes.
  function automatic strobe_t step_strobes(input logic [2:0] s);
    strobe_t r;
    r = '0;
    case (s)
      SEQ_STEP_0, SEQ_STEP_4: r.length = 1'b1;
      SEQ_STEP_2, SEQ_STEP_6: begin
        r.length = 1'b1;
        r.sweep  = 1'b1;
      end
      SEQ_STEP_7: r.envelope = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sound_frame_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | sound_frame_sequencer_if : register-file <-> sequencer signal bundle      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface sound_frame_sequencer_if;
  logic       master_enable;
  logic [3:0] trigger;
  logic [3:0] length_en;
  logic [3:0] length_wr;
  logic [7:0] length_data;
  logic       length_tick;
  logic       sweep_tick;
  logic       envelope_tick;
  logic [2:0] step;
  logic [3:0] ch_on;

  modport master (
    output master_enable, trigger, length_en, length_wr, length_data,
    input  length_tick, sweep_tick, envelope_tick, step, ch_on
  );

  modport slave (
    input  master_enable, trigger, length_en, length_wr, length_data,
    output length_tick, sweep_tick, envelope_tick, step, ch_on
  );
endinterface

`default_nettype wire

// File: rtl/sound_length_counter.sv
// +--------------------------------------------------------------------------+
// | sound_length_counter : per-channel length counter and channel-on flag     |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sound_length_counter
  import sound_pkg::*;
#(
  parameter int MAX = LEN_MAX_TONE
) (
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic       master_enable,
  input  wire logic       wr,
  input  wire logic [7:0] data,
  input  wire logic       trigger,
  input  wire logic       tick,
  input  wire logic       en,
  output logic            on
);

  localparam logic [8:0] MAX_V     = 9'(MAX);
  localparam logic [8:0] DATA_MASK = 9'(MAX - 1);

  logic [8:0] count;
  logic [8:0] written;

  // A write in the same cycle as a trigger is applied first so the trigger sees it.
  always_comb begin
    written = count;
    if (wr) begin
      written = MAX_V - ({1'b0, data} & DATA_MASK);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !master_enable) begin
      count <= '0;
      on    <= 1'b0;
    end else if (trigger) begin
      on    <= 1'b1;
      count <= (written == 9'd0) ? MAX_V : written;
    end else if (wr) begin
      count <= written;
    end else if (tick && en && (count != 9'd0)) begin
      count <= count - 9'd1;
      if (count == 9'd1) begin
        on <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sound_frame_sequencer.sv
// +--------------------------------------------------------------------------+
// | sound_frame_sequencer : 512 Hz frame sequencer, strobes, length counters  |
// | Build option: SOUND_SEQ_FASTSIM_EN forces the step divider to 16.         |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sound_frame_sequencer
  import sound_pkg::*;
#(
  parameter int CLK_DIV = 8192
) (
  input  wire logic             clock,
  input  wire logic             reset,
  sound_frame_sequencer_if.slave bus
);

`ifdef SOUND_SEQ_FASTSIM_EN
  localparam int DIV = 16;
`else
  localparam int DIV = CLK_DIV;
`endif
  localparam int              DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       step_r;
  strobe_t          strobes;
  logic [3:0]       ch_on;

  // Each step executes on the divider wrap; strobes last exactly one cycle.
  always_ff @(posedge clock) begin
    if (reset || !bus.master_enable) begin
      div_cnt <= '0;
      step_r  <= SEQ_STEP_0;
      strobes <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
      step_r  <= step_r + 3'd1;
      strobes <= step_strobes(step_r);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      strobes <= '0;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_len
    sound_length_counter #(
      .MAX((i == CH3) ? LEN_MAX_WAVE : LEN_MAX_TONE)
    ) u_len (
      .clock         (clock),
      .reset         (reset),
      .master_enable (bus.master_enable),
      .wr            (bus.length_wr[i]),
      .data          (bus.length_data),
      .trigger       (bus.trigger[i]),
      .tick          (strobes.length),
      .en            (bus.length_en[i]),
      .on            (ch_on[i])
    );
  end

  assign bus.length_tick   = strobes.length;
  assign bus.sweep_tick    = strobes.sweep;
  assign bus.envelope_tick = strobes.envelope;
  assign bus.step          = step_r;
  assign bus.ch_on         = ch_on;

endmodule

`default_nettype wire

// File: tb/tb_sound_frame_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_sound_frame_sequencer : directed bench for sound_frame_sequencer       |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sound_frame_sequencer;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  sound_frame_sequencer_if bus ();

  sound_frame_sequencer #(.CLK_DIV(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Leaves the bench in the cycle where master_enable=1 is first sampled next edge.
  task automatic restart();
    bus.master_enable = 1'b0;
    bus.trigger       = '0;
    bus.length_wr     = '0;
    bus.length_en     = '0;
    bus.length_data   = '0;
    edges(1);
    bus.master_enable = 1'b1;
  endtask

  // Returns in the cycle the n-th length_tick is high.
  task automatic wait_ticks(input int n, input string tag);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < n * 64 + 64) begin
      edges(1);
      cyc++;
      if (bus.length_tick) seen++;
    end
    chk(tag, seen, n);
  endtask

  task automatic wait_step(input logic [2:0] s, input string tag);
    int cyc = 0;
    while (bus.step !== s && cyc < 256) begin
      edges(1);
      cyc++;
    end
    chk(tag, bus.step, s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    bus.master_enable = 1'b0;
    bus.trigger       = '0;
    bus.length_en     = '0;
    bus.length_wr     = '0;
    bus.length_data   = '0;
    edges(3);
    chk("rst_length_tick", bus.length_tick, 0);
    chk("rst_sweep_tick", bus.sweep_tick, 0);
    chk("rst_envelope_tick", bus.envelope_tick, 0);
    chk("rst_step", bus.step, 0);
    chk("rst_ch_on", bus.ch_on, 0);

    // Reset must override an asserted master_enable and trigger.
    bus.master_enable = 1'b1;
    bus.trigger       = 4'b1111;
    edges(20);
    chk("rst_override_step", bus.step, 0);
    chk("rst_override_ch_on", bus.ch_on, 0);
    chk("rst_override_tick", bus.length_tick, 0);
    bus.trigger = '0;

    // Frame timing from the first enabled edge.
    reset = 1'b0;
    edges(15);
    chk("e15_length", bus.length_tick, 0);
    edges(1);
    chk("e16_length", bus.length_tick, 1);
    chk("e16_step", bus.step, 1);
    chk("e16_sweep", bus.sweep_tick, 0);
    edges(1);
    chk("e17_length", bus.length_tick, 0);
    edges(31);
    chk("e48_sweep", bus.sweep_tick, 1);
    chk("e48_length", bus.length_tick, 1);
    chk("e48_step", bus.step, 3);
    edges(1);
    chk("e49_sweep", bus.sweep_tick, 0);
    edges(79);
    chk("e128_envelope", bus.envelope_tick, 1);
    chk("e128_length", bus.length_tick, 0);
    chk("e128_step", bus.step, 0);
    edges(16);
    chk("e144_length", bus.length_tick, 1);
    chk("e144_step", bus.step, 1);

    // Channel 1: write 62 together with trigger -> counter 2.
    restart();
    bus.length_wr   = 4'b0001;
    bus.length_data = 8'd62;
    bus.trigger     = 4'b0001;
    bus.length_en   = 4'b0001;
    edges(1);
    bus.length_wr = '0;
    bus.trigger   = '0;
    chk("ch1_on_trig", bus.ch_on[0], 1);
    wait_ticks(1, "ch1_tick1");
    edges(1);
    chk("ch1_on_after_tick1", bus.ch_on[0], 1);
    wait_ticks(1, "ch1_tick2");
    chk("ch1_on_at_tick2", bus.ch_on[0], 1);
    edges(1);
    chk("ch1_off_after_tick2", bus.ch_on[0], 0);

    // Channel 3: length_data 0 loads 256.
    restart();
    bus.length_wr   = 4'b0100;
    bus.length_data = 8'd0;
    edges(1);
    bus.length_wr = '0;
    bus.trigger   = 4'b0100;
    bus.length_en = 4'b0100;
    edges(1);
    bus.trigger = '0;
    chk("ch3_on_trig", bus.ch_on[2], 1);
    wait_ticks(255, "ch3_tick255");
    edges(1);
    chk("ch3_on_after_255", bus.ch_on[2], 1);
    wait_ticks(1, "ch3_tick256");
    edges(1);
    chk("ch3_off_after_256", bus.ch_on[2], 0);
    chk("ch3_others_off", bus.ch_on, 0);

    // Channel 2: length disabled for two frames, counter stays 64.
    restart();
    bus.trigger = 4'b0010;
    edges(1);
    bus.trigger = '0;
    edges(256);
    chk("ch2_on_held", bus.ch_on[1], 1);
    bus.length_en = 4'b0010;
    wait_ticks(63, "ch2_tick63");
    edges(1);
    chk("ch2_on_after_63", bus.ch_on[1], 1);
    wait_ticks(1, "ch2_tick64");
    edges(1);
    chk("ch2_off_after_64", bus.ch_on[1], 0);

    // Channel 4: trigger coincides with a length tick while counter=1.
    restart();
    bus.length_wr   = 4'b1000;
    bus.length_data = 8'd63;
    edges(1);
    bus.length_wr = '0;
    wait_ticks(1, "ch4_first_tick");
    bus.trigger   = 4'b1000;
    bus.length_en = 4'b1000;
    edges(1);
    bus.trigger = '0;
    chk("ch4_on_trig_tick", bus.ch_on[3], 1);
    wait_ticks(1, "ch4_next_tick");
    chk("ch4_on_at_next_tick", bus.ch_on[3], 1);
    edges(1);
    chk("ch4_off_after_next", bus.ch_on[3], 0);

    // master_enable dropped at step 5 with all channels on.
    restart();
    bus.trigger = 4'b1111;
    edges(1);
    bus.trigger = '0;
    chk("dis_all_on", bus.ch_on, 4'hF);
    wait_step(3'd5, "dis_reach_step5");
    chk("dis_length_high", bus.length_tick, 1);
    bus.master_enable = 1'b0;
    edges(1);
    chk("dis_ch_on", bus.ch_on, 0);
    chk("dis_step", bus.step, 0);
    chk("dis_length", bus.length_tick, 0);
    chk("dis_sweep", bus.sweep_tick, 0);
    chk("dis_envelope", bus.envelope_tick, 0);
    bus.trigger     = 4'b0001;
    bus.length_wr   = 4'b0001;
    bus.length_data = 8'd10;
    edges(1);
    bus.trigger   = '0;
    bus.length_wr = '0;
    chk("dis_trigger_ignored", bus.ch_on, 0);
    edges(20);
    chk("dis_step_held", bus.step, 0);
    chk("dis_no_strobe", bus.length_tick, 0);
    bus.master_enable = 1'b1;
    edges(15);
    chk("reen_e15_length", bus.length_tick, 0);
    edges(1);
    chk("reen_e16_length", bus.length_tick, 1);
    chk("reen_e16_step", bus.step, 1);

    // Mid-frame reset clears channel state and step.
    bus.trigger = 4'b0001;
    edges(1);
    bus.trigger = '0;
    chk("mid_ch_on", bus.ch_on, 4'b0001);
    reset = 1'b1;
    edges(1);
    chk("mid_rst_ch_on", bus.ch_on, 0);
    chk("mid_rst_step", bus.step, 0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
